// File: rtl/mat_vec_sequencer.sv
// mat_vec_sequencer: drives one 4-lane dot-product unit row by row to form a 4x4 matrix times 4-vector product.
module mat_vec_sequencer #(
    parameter int WIDTH       = 32,
    parameter int DOT_LATENCY = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WIDTH-1:0]   m_in,
    input  logic [4*WIDTH-1:0]    v_in,
    output logic [4*WIDTH-1:0]    dp_x,
    output logic [4*WIDTH-1:0]    dp_y,
    input  logic [WIDTH-1:0]      dp_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*WIDTH-1:0]    out_vec,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [1:0]             row_q, cap_q, row_d;
    logic [DOT_LATENCY-1:0] tag_q, tag_d;
    logic [4*WIDTH-1:0]     rows_q [4];
    logic [4*WIDTH-1:0]     dp_x_q, dp_y_q;
    logic [WIDTH-1:0]       res_q [4];
    logic                   cap_en;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dp_x      = dp_x_q;
    assign dp_y      = dp_y_q;
    assign row_d     = row_q + 2'd1;
    // A tag marks every cycle with live operands; it emerges as that row's result appears.
    assign tag_d     = (tag_q << 1) | DOT_LATENCY'(state_q == ISSUE);
    assign cap_en    = tag_q[DOT_LATENCY-1];

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign out_vec[g*WIDTH +: WIDTH] = res_q[g];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            row_q   <= '0;
            cap_q   <= '0;
            tag_q   <= '0;
            dp_x_q  <= '0;
            dp_y_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                rows_q[i] <= '0;
                res_q[i]  <= '0;
            end
        end else begin
            tag_q <= tag_d;
            if (cap_en) begin
                res_q[cap_q] <= dp_out;
                cap_q        <= cap_q + 2'd1;
            end
            case (state_q)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < 4; i++) rows_q[i] <= m_in[i*4*WIDTH +: 4*WIDTH];
                    dp_x_q  <= m_in[0 +: 4*WIDTH];
                    dp_y_q  <= v_in;
                    row_q   <= '0;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    row_q <= row_d;
                    if (row_q == 2'd3) begin
                        dp_x_q  <= '0;
                        dp_y_q  <= '0;
                        state_q <= DRAIN;
                    end else begin
                        dp_x_q <= rows_q[row_d];
                    end
                end
                DRAIN: if (cap_en && cap_q == 2'd3) state_q <= DONE;
                DONE:  if (out_ready) state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_vec_sequencer.sv
// tb_mat_vec_sequencer: table, hand-written and random jobs against a matrix-vector reference with a dot-unit model.
module tb_mat_vec_sequencer;
    logic clk, rst_in;
    logic in_valid, in_ready, out_valid, out_ready, busy;
    logic [511:0] m_in;
    logic [127:0] v_in, dp_x, dp_y, out_vec;
    logic [31:0]  dp_out;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [511:0] b_m_in;
    logic [127:0] b_v_in, b_dp_x, b_dp_y, b_out_vec;
    logic [31:0]  b_dp_out;
    int checks = 0, errors = 0;

    mat_vec_sequencer #(.WIDTH(32), .DOT_LATENCY(3)) dut (
        .clk_in(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
        .m_in(m_in), .v_in(v_in), .dp_x(dp_x), .dp_y(dp_y), .dp_out(dp_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .busy(busy));

    mat_vec_sequencer #(.WIDTH(32), .DOT_LATENCY(1)) dut_b (
        .clk_in(clk), .rst_in(rst_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .m_in(b_m_in), .v_in(b_v_in), .dp_x(b_dp_x), .dp_y(b_dp_y), .dp_out(b_dp_out),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec), .busy(b_busy));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dot(input logic [127:0] x, input logic [127:0] y);
        int s;
        s = 0;
        for (int c = 0; c < 4; c++) s += int'(x[c*32 +: 32]) * int'(y[c*32 +: 32]);
        return s;
    endfunction

    function automatic logic [127:0] matvec(input logic [511:0] m, input logic [127:0] v);
        logic [127:0] r;
        int acc;
        for (int i = 0; i < 4; i++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) acc += int'(m[(4*i+c)*32 +: 32]) * int'(v[c*32 +: 32]);
            r[i*32 +: 32] = acc;
        end
        return r;
    endfunction

    // Dot-product units without reset: latency 3 for dut, latency 1 for dut_b.
    logic [31:0] pa [3];
    logic [31:0] pb;
    always @(posedge clk) begin
        pa[0] <= dot(dp_x, dp_y);
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        pb    <= dot(b_dp_x, b_dp_y);
    end
    assign dp_out   = pa[2];
    assign b_dp_out = pb;

    typedef struct packed {
        logic [15:0][31:0] m;
        logic [3:0][31:0]  v;
        logic [3:0][31:0]  e;
        logic [3:0]        hold;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [511:0] m, input logic [127:0] v, input bit keep);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready before send", {127'd0, in_ready}, 128'd1);
        m_in = m;
        v_in = v;
        in_valid = 1;
        @(negedge clk);
        if (!keep) in_valid = 0;
    endtask

    task automatic wait_valid(input int exp_lat, input logic [127:0] exp, input string nm);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, 128'(lat), 128'(exp_lat));
        check({nm, " out_vec"}, out_vec, exp);
    endtask

    task automatic run_job(input logic [511:0] m, input logic [127:0] v, input logic [127:0] exp,
                           input int hold, input string nm);
        logic [127:0] snap;
        out_ready = (hold == 0);
        send(m, v, 0);
        check({nm, " busy"}, {127'd0, busy}, 128'd1);
        wait_valid(8, exp, nm);
        snap = out_vec;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({nm, " held valid"}, {127'd0, out_valid}, 128'd1);
            check({nm, " held vec"}, out_vec, snap);
            check({nm, " held in_ready"}, {127'd0, in_ready}, 128'd0);
            check({nm, " held busy"}, {127'd0, busy}, 128'd1);
            if (k == hold - 1) out_ready = 1;
        end
        @(negedge clk);
        check({nm, " valid drop"}, {127'd0, out_valid}, 128'd0);
        check({nm, " ready back"}, {127'd0, in_ready}, 128'd1);
        check({nm, " idle"}, {127'd0, busy}, 128'd0);
    endtask

    initial begin
        logic [511:0] rm;
        logic [127:0] rv;
        int cnt, lat;
        rst_in = 1; in_valid = 0; out_ready = 1; m_in = '0; v_in = '0;
        b_in_valid = 0; b_out_ready = 1; b_m_in = '0; b_v_in = '0;
        for (int i = 0; i < 16; i++) begin
            tbl[0].m[i] = (i / 4 == i % 4) ? 32'd1 : 32'd0;
            tbl[2].m[i] = 32'(i);
            tbl[3].m[i] = 32'hFFFF_FFFF;
            tbl[1].m[i] = (i >= 8 && i < 12) ? 32'd1 : 32'd0;
        end
        tbl[1].m[0] = -32'sd1; tbl[1].m[1] = 32'd2; tbl[1].m[2] = -32'sd3; tbl[1].m[3] = 32'd4;
        tbl[1].m[12] = 32'd2;
        for (int c = 0; c < 4; c++) begin
            tbl[0].v[c] = 32'(c + 1);
            tbl[1].v[c] = 32'(c + 5);
            tbl[2].v[c] = 32'd1;
            tbl[3].v[c] = (c % 2 == 0) ? 32'(c + 1) : -32'(c + 1);
            tbl[0].e[c] = 32'(c + 1);
            tbl[2].e[c] = 32'(6 + 16 * c);
            tbl[3].e[c] = 32'd2;
        end
        tbl[1].e[0] = 32'd18; tbl[1].e[1] = 32'd0; tbl[1].e[2] = 32'd26; tbl[1].e[3] = 32'd10;
        tbl[0].hold = 0; tbl[1].hold = 5; tbl[2].hold = 1; tbl[3].hold = 0;

        repeat (3) @(negedge clk);
        check("reset in_ready", {127'd0, in_ready}, 128'd1);
        check("reset out_valid", {127'd0, out_valid}, 128'd0);
        check("reset busy", {127'd0, busy}, 128'd0);
        check("reset dp_x", dp_x, 128'd0);
        check("reset dp_y", dp_y, 128'd0);
        check("reset out_vec", out_vec, 128'd0);
        check("reset b dp_x", b_dp_x, 128'd0);
        rst_in = 0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_job(tbl[i].m, tbl[i].v, tbl[i].e, int'(tbl[i].hold), $sformatf("tbl%0d", i));

        // Back-to-back: second job waits on in_valid while the first drains.
        out_ready = 1;
        send(tbl[1].m, tbl[1].v, 1);
        m_in = tbl[2].m;
        v_in = tbl[2].v;
        wait_valid(8, tbl[1].e, "b2b first");
        @(negedge clk);
        check("b2b ready after transfer", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        in_valid = 0;
        check("b2b second accepted", {127'd0, busy}, 128'd1);
        wait_valid(8, tbl[2].e, "b2b second");
        @(negedge clk);
        check("b2b second done", {127'd0, out_valid}, 128'd0);

        // Asynchronous reset in the middle of cycle 5.
        send(tbl[3].m, tbl[3].v, 0);
        repeat (4) @(negedge clk);
        #2 rst_in = 1;
        #1;
        check("abort out_valid", {127'd0, out_valid}, 128'd0);
        check("abort in_ready", {127'd0, in_ready}, 128'd1);
        check("abort busy", {127'd0, busy}, 128'd0);
        check("abort dp_x", dp_x, 128'd0);
        check("abort dp_y", dp_y, 128'd0);
        check("abort out_vec", out_vec, 128'd0);
        @(negedge clk);
        rst_in = 0;
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("abort no result", 128'(cnt), 128'd0);
        run_job(tbl[1].m, tbl[1].v, tbl[1].e, 0, "after abort");

        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < 16; i++) rm[i*32 +: 32] = $urandom;
            for (int c = 0; c < 4; c++) rv[c*32 +: 32] = $urandom;
            run_job(rm, rv, matvec(rm, rv), $urandom_range(0, 3), $sformatf("rand%0d", j));
        end

        // Latency-1 instance.
        b_m_in = tbl[2].m;
        b_v_in = tbl[2].v;
        b_in_valid = 1;
        @(negedge clk);
        b_in_valid = 0;
        lat = 1;
        while (!b_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("lat1 latency", 128'(lat), 128'd6);
        check("lat1 out_vec", b_out_vec, matvec(tbl[2].m, tbl[2].v));
        check("lat1 table", b_out_vec, tbl[2].e);
        @(negedge clk);
        check("lat1 done", {127'd0, b_out_valid}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mat_vec_sequencer.md
Name: mat_vec_sequencer

Overview:
- Sequences one external 4-lane dot-product pipeline to compute a 4x4 matrix times 4-vector product, e.g. vertex transforms in the render pipeline.
- Accepts a matrix and a vector on a valid/ready input handshake.
- Issues one matrix row per cycle to the dot-product unit and tracks in-flight rows with a tag pipeline.
- Collects the four scalar results and presents the vector on a valid/ready output handshake.

Parameters:
- WIDTH, 32, element width in bits (signed); must match the dot-product unit's WIDTH.
- DOT_LATENCY, 3, cycles from operands driven on dp_x/dp_y to the result valid on dp_out; legal range 1..8.

Ports:
- clk_in  in  1  system clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- in_valid  in  1  m_in/v_in hold a job.
- in_ready  out  1  block can accept a job.
- m_in  in  16*WIDTH  matrix; element (r,c) at bits [(4r+c)*WIDTH +: WIDTH].
- v_in  in  4*WIDTH  vector; element c at bits [c*WIDTH +: WIDTH].
- dp_x  out  4*WIDTH  row operands to the dot-product unit, lane c = m(r,c).
- dp_y  out  4*WIDTH  vector operands to the dot-product unit, lane c = v(c).
- dp_out  in  WIDTH  dot-product result.
- out_valid  out  1  out_vec holds a completed result.
- out_ready  in  1  downstream accepts the result.
- out_vec  out  4*WIDTH  result; element r at bits [r*WIDTH +: WIDTH] = row r · v.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: while rst_in is high, outputs and registers are forced to these values.
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - dp_x = 0, dp_y = 0, out_vec = 0.
  - Row counter, capture counter and tag pipeline are cleared.
- Reset mid-job: the job and all in-flight rows are discarded. No out_valid is produced for that job. The dot-product unit has no reset, so its stale outputs are ignored because all tags are cleared.
- in_ready = (state == IDLE), driven combinationally from state. A job is accepted on a clock edge where in_valid && in_ready; m_in and v_in are latched into internal registers.
- State machine:
  - IDLE → ISSUE on accept.
  - ISSUE lasts exactly 4 cycles, r = 0..3.
    - In cycle r, registered dp_x = row r and dp_y = latched v.
    - A tag bit 1 enters a DOT_LATENCY-deep shift register.
    - After r = 3, go to DRAIN.
  - DRAIN: when the tag reaches the end of the shift register, dp_out is captured into out_vec element cap_idx and cap_idx increments. Results are captured in row order 0..3.
    - When the 4th capture occurs, go to DONE.
  - DONE: out_valid = 1. out_vec and out_valid are held stable until out_ready is high.
    - On the out_valid && out_ready edge, go to IDLE.
    - out_valid is low the following cycle.
- Operand timing: operands driven during cycle k produce a valid dp_out during cycle k + DOT_LATENCY. They are captured on the edge that ends that cycle.
- Tag pipeline: a tag issued in cycle k is present at the pipeline output during cycle k + DOT_LATENCY.
- Overall latency: with the accept edge ending cycle 0, out_valid first goes high in cycle 5 + DOT_LATENCY, i.e. cycle 8 for the default.
- No new accept happens while a job is in flight or a result is unclaimed. A new accept can happen no earlier than the cycle after the output transfer, so minimum job spacing is 6 + DOT_LATENCY cycles.
- Capture can also occur during ISSUE when DOT_LATENCY < 4. The capture counter runs independently of state; DONE is entered only after 4 captures and ISSUE has completed.
- dp_x and dp_y are driven to 0 in every non-ISSUE cycle.
- Arithmetic: the block itself does no arithmetic. out_vec elements are dp_out copied bit-exact. Fixed-point versus integer handling is the dot-product unit's concern.
- out_vec retains the last result after transfer until the next capture overwrites it.

Test Plan:
- Identity matrix, v = (1,2,3,4), integer mode, out_ready = 1 → out_vec = (1,2,3,4), out_valid high exactly 8 cycles after the accept edge, for 1 cycle.
- Rows (-1,2,-3,4), (0,0,0,0), (1,1,1,1), (2,0,0,0) times v = (5,6,7,8) → out_vec = (18, 0, 26, 10).
- Backpressure, out_ready held low 5 cycles after out_valid → out_valid stays 1, out_vec stable, in_ready stays 0, busy stays 1.
  - Then out_ready = 1 → transfer occurs, in_ready = 1 the next cycle.
- Back-to-back jobs with in_valid held high and the second job presented right after the first transfer → second job accepted the cycle in_ready returns; both results correct; spacing 9 cycles.
- Assert rst_in asynchronously in cycle 5 of a job → outputs reach reset values immediately.
  - After release, no out_valid for the aborted job.
  - The next job's result is correct and unaffected by stale dp_out values.
- DOT_LATENCY = 1 with a matching bench pipeline model, matrix with (r,c) = r*4+c and v = (1,1,1,1) → out_vec = (6, 22, 38, 54), out_valid in cycle 6.
